hub75_bcm_scan_ctrl: RTL
========================

// Module: hub75_bcm_scan_ctrl
// PURPOSE
//  Row-scan controller for HUB75 panels using binary-coded modulation (BCM). Sequences bitplanes per row
//  and commands the pixel shifter (o_tx_start/i_tx_ready). Drives latch, OE_n and row address directly;
//  shifts the next plane while the current plane is displayed. Adds runtime bit depth, BCM-weighted
//  on-time, ghosting dead time and an underflow counter; sits between the frame buffer reader and the pins.
// PARAMETERS
//  HPIXEL      64  panel width in pixels
//  VPIXEL      64  panel height in pixels
//  BPP         8   bits per colour channel stored in frame buffer
//  SEGMENTS    2   simultaneously driven segments; ROWS = VPIXEL/SEGMENTS
//  LEN_WD      8   width of i_base_len
//  DEAD_CYC    2   OE_n-high cycles before and after every latch (>=1)
// PORTS
//  clk           in   1                     system clock
//  rst           in   1                     synchronous reset, active-high
//  i_enable      in   1                     run scan; low = stop at next plane boundary
//  i_bits        in   $clog2(BPP+1)         active bit depth 1..BPP, sampled at frame start
//  i_base_len    in   LEN_WD                LSB-plane on-time in clk cycles (0 treated as 1)
//  i_clr_uflow   in   1                     clear o_uflow_cnt
//  o_tx_start    out  1                     1-cycle pulse: shift plane o_pix_bit of row at o_init_addr
//  o_init_addr   out  $clog2(HPIXEL*VPIXEL) first pixel address of shifted row = row*HPIXEL
//  o_pix_bit     out  $clog2(BPP)           bitplane index being shifted
//  i_tx_ready    in   1                     shifter idle; drops the cycle after o_tx_start, high when done
//  o_latch       out  1                     panel LAT, 1-cycle pulse
//  o_oe_n        out  1                     panel OE, active low
//  o_row_addr    out  $clog2(ROWS)          panel A..E row select of displayed row
//  o_frame_start out  1                     1-cycle pulse at latch of row 0, first plane
//  o_frame_done  out  1                     1-cycle pulse at end of display of last plane of row ROWS-1
//  o_uflow_cnt   out  16                    saturating count of underflow events
// BEHAVIOUR
//  Reset: all pulses 0, o_oe_n=1, o_row_addr/o_init_addr/o_pix_bit/o_uflow_cnt=0, state IDLE.
//  Plane order per row: LSB first, planes k=0..NB-1, o_pix_bit = BPP-NB+k (MSBs kept).
//  NB = i_bits captured when plane 0 of row 0 is issued; 0 or >BPP clamps to BPP.
//  Plane k on-time = max(i_base_len,1) << k cycles exactly; counter width LEN_WD+BPP, no overflow.
//  States: IDLE, PRELOAD, LATCH, DEAD, DISPLAY, BLANK.
//   IDLE: oe_n=1. i_enable & i_tx_ready -> o_tx_start (row 0, first plane) -> PRELOAD.
//   PRELOAD: wait i_tx_ready high (ignore cycle after start) -> LATCH.
//   LATCH: o_latch=1 one cycle; o_row_addr <= row of latched plane same edge -> DEAD.
//   DEAD: oe_n=1 for DEAD_CYC cycles -> DISPLAY.
//   DISPLAY: oe_n=0 for on-time; first cycle issues o_tx_start for next plane (next row / row 0
//    on wrap) if i_enable, else none -> BLANK.
//   BLANK: oe_n=1 >= DEAD_CYC cycles; then LATCH once shift complete, or IDLE if no start was issued.
//  Underflow: shift not complete after DEAD_CYC in BLANK -> o_uflow_cnt+1 once per plane; keep
//   oe_n=1 and wait (never latch partial data). Counter saturates at 16'hFFFF.
//  i_clr_uflow concurrent with an underflow event: clear wins, count = 0.
//  o_tx_start only when i_tx_ready=1; i_tx_ready high when start is due but low: hold start.
//  Row wrap: after last plane of row ROWS-1 next row is 0; o_frame_done and next shift start in
//   same frame boundary; o_frame_start at the following LATCH.
//  rst mid-operation: next edge returns to reset values (oe_n=1, latch 0) regardless of state.
//  i_bits/i_base_len changes mid-frame: i_bits ignored until next frame; i_base_len read at DISPLAY entry.
// TESTING
//  (HPIXEL=64,VPIXEL=64,BPP=8,SEGMENTS=2,DEAD_CYC=2, shifter model busy 10 cycles)
//  1 Reset mid-DISPLAY -> next cycle o_oe_n=1, o_latch=0, o_row_addr=0, o_uflow_cnt=0; restarts from PRELOAD.
//  2 i_bits=8, base=4 -> o_pix_bit 0..7, OE_n-low widths 4,8,..,512; row 1 o_init_addr=64; no underflow.
//  3 i_bits=3, base=4 -> o_pix_bit 5,6,7 widths 4,8,16; i_bits=0 -> behaves as 8.
//  4 Shifter busy 100, base=4 -> o_uflow_cnt increments once per short plane; no latch before i_tx_ready.
//  5 Run to row 31 plane 7 -> o_frame_done pulse, next o_init_addr=0, o_row_addr=0, o_frame_start pulse.
//  6 i_enable low mid-row -> current plane finishes, no further o_tx_start, IDLE with o_oe_n=1.

Source files
------------

// File: rtl/hub75_bcm_scan_ctrl.sv
// HUB75 row-scan controller with binary-coded modulation: the next bitplane is shifted
// while the current one is displayed, LSB plane first, with dead time around every latch.
module hub75_bcm_scan_ctrl #(
    parameter int HPIXEL   = 64,
    parameter int VPIXEL   = 64,
    parameter int BPP      = 8,
    parameter int SEGMENTS = 2,
    parameter int LEN_WD   = 8,
    parameter int DEAD_CYC = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                i_enable,
    input  logic [$clog2(BPP+1)-1:0]            i_bits,
    input  logic [LEN_WD-1:0]                   i_base_len,
    input  logic                                i_clr_uflow,
    output logic                                o_tx_start,
    output logic [$clog2(HPIXEL*VPIXEL)-1:0]    o_init_addr,
    output logic [$clog2(BPP)-1:0]              o_pix_bit,
    input  logic                                i_tx_ready,
    output logic                                o_latch,
    output logic                                o_oe_n,
    output logic [$clog2(VPIXEL/SEGMENTS)-1:0]  o_row_addr,
    output logic                                o_frame_start,
    output logic                                o_frame_done,
    output logic [15:0]                         o_uflow_cnt
);
    localparam int ROWS   = VPIXEL / SEGMENTS;
    localparam int BITS_W = $clog2(BPP + 1);
    localparam int ADDR_W = $clog2(HPIXEL * VPIXEL);
    localparam int PB_W   = $clog2(BPP);
    localparam int ROW_W  = $clog2(ROWS);
    localparam int CNT_W  = LEN_WD + BPP;
    localparam int DC_W   = $clog2(DEAD_CYC + 1);

    typedef enum logic [2:0] {S_IDLE, S_PRELOAD, S_LATCH, S_DEAD, S_DISPLAY, S_BLANK} state_t;

    state_t              state_reg;
    logic [BITS_W-1:0]   nb_reg, sh_k_reg, disp_k_reg;
    logic [ROW_W-1:0]    sh_row_reg, row_addr_reg;
    logic                pend_reg, start_req_reg, uflow_seen_reg, disp_last_reg;
    logic [CNT_W-1:0]    on_cnt_reg;
    logic [DC_W-1:0]     dcnt_reg;
    logic                tx_start_reg, latch_reg, oe_n_reg, frame_start_reg, frame_done_reg;
    logic [ADDR_W-1:0]   init_addr_reg;
    logic [PB_W-1:0]     pix_bit_reg;
    logic [15:0]         uflow_cnt_reg;

    logic [BITS_W-1:0]   bits_eff, nxt_k, nxt_nb;
    logic [ROW_W-1:0]    nxt_row;
    logic [PB_W-1:0]     nxt_bit, first_bit;
    logic [ADDR_W-1:0]   nxt_addr;
    logic [LEN_WD-1:0]   base_eff;
    logic [CNT_W-1:0]    on_time;
    logic                shift_done, blank_ok, latch_go, uflow_evt;

    always_comb begin
        bits_eff = i_bits;
        if (i_bits == '0 || i_bits > BITS_W'(BPP))
            bits_eff = BITS_W'(BPP);
        // Successor of the plane most recently shifted; bit depth is re-sampled only on frame wrap
        nxt_row = sh_row_reg;
        nxt_k   = sh_k_reg + BITS_W'(1);
        nxt_nb  = nb_reg;
        if (sh_k_reg == nb_reg - BITS_W'(1)) begin
            nxt_k = '0;
            if (sh_row_reg == ROW_W'(ROWS - 1)) begin
                nxt_row = '0;
                nxt_nb  = bits_eff;
            end else begin
                nxt_row = sh_row_reg + ROW_W'(1);
            end
        end
        nxt_bit    = PB_W'(BPP - int'(nxt_nb) + int'(nxt_k));
        first_bit  = PB_W'(BPP - int'(bits_eff));
        nxt_addr   = ADDR_W'(int'(nxt_row) * HPIXEL);
        base_eff   = (i_base_len == '0) ? LEN_WD'(1) : i_base_len;
        on_time    = CNT_W'(base_eff) << disp_k_reg;
        // Ready is stale while our own start pulse is still on the wire
        shift_done = i_tx_ready && !tx_start_reg && !start_req_reg;
        blank_ok   = (state_reg == S_BLANK) && (dcnt_reg >= DC_W'(DEAD_CYC - 1));
        latch_go   = pend_reg && shift_done && ((state_reg == S_PRELOAD) || blank_ok);
        uflow_evt  = pend_reg && blank_ok && !shift_done && !uflow_seen_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            nb_reg          <= BITS_W'(BPP);
            sh_k_reg        <= '0;
            sh_row_reg      <= '0;
            disp_k_reg      <= '0;
            disp_last_reg   <= 1'b0;
            pend_reg        <= 1'b0;
            start_req_reg   <= 1'b0;
            uflow_seen_reg  <= 1'b0;
            on_cnt_reg      <= '0;
            dcnt_reg        <= '0;
            tx_start_reg    <= 1'b0;
            init_addr_reg   <= '0;
            pix_bit_reg     <= '0;
            latch_reg       <= 1'b0;
            oe_n_reg        <= 1'b1;
            row_addr_reg    <= '0;
            frame_start_reg <= 1'b0;
            frame_done_reg  <= 1'b0;
            uflow_cnt_reg   <= '0;
        end else begin
            tx_start_reg    <= 1'b0;
            latch_reg       <= 1'b0;
            frame_start_reg <= 1'b0;
            frame_done_reg  <= 1'b0;
            if (start_req_reg && i_tx_ready) begin
                tx_start_reg  <= 1'b1;
                start_req_reg <= 1'b0;
            end
            case (state_reg)
                S_IDLE: begin
                    oe_n_reg <= 1'b1;
                    if (i_enable && i_tx_ready) begin
                        tx_start_reg  <= 1'b1;
                        nb_reg        <= bits_eff;
                        sh_row_reg    <= '0;
                        sh_k_reg      <= '0;
                        init_addr_reg <= '0;
                        pix_bit_reg   <= first_bit;
                        pend_reg      <= 1'b1;
                        state_reg     <= S_PRELOAD;
                    end
                end
                S_PRELOAD: begin
                end
                S_LATCH: begin
                    dcnt_reg  <= '0;
                    state_reg <= S_DEAD;
                end
                S_DEAD: begin
                    if (dcnt_reg >= DC_W'(DEAD_CYC - 1)) begin
                        oe_n_reg   <= 1'b0;
                        on_cnt_reg <= on_time - CNT_W'(1);
                        state_reg  <= S_DISPLAY;
                        if (i_enable) begin
                            pend_reg      <= 1'b1;
                            sh_row_reg    <= nxt_row;
                            sh_k_reg      <= nxt_k;
                            nb_reg        <= nxt_nb;
                            init_addr_reg <= nxt_addr;
                            pix_bit_reg   <= nxt_bit;
                            if (i_tx_ready)
                                tx_start_reg <= 1'b1;
                            else
                                start_req_reg <= 1'b1;
                        end
                    end else begin
                        dcnt_reg <= dcnt_reg + DC_W'(1);
                    end
                end
                S_DISPLAY: begin
                    if (on_cnt_reg == '0) begin
                        oe_n_reg       <= 1'b1;
                        frame_done_reg <= disp_last_reg;
                        dcnt_reg       <= '0;
                        uflow_seen_reg <= 1'b0;
                        state_reg      <= S_BLANK;
                    end else begin
                        on_cnt_reg <= on_cnt_reg - CNT_W'(1);
                    end
                end
                S_BLANK: begin
                    if (!blank_ok)
                        dcnt_reg <= dcnt_reg + DC_W'(1);
                    else if (!pend_reg)
                        state_reg <= S_IDLE;
                    if (uflow_evt)
                        uflow_seen_reg <= 1'b1;
                end
                default: state_reg <= S_IDLE;
            endcase
            if (latch_go) begin
                latch_reg       <= 1'b1;
                row_addr_reg    <= sh_row_reg;
                frame_start_reg <= (sh_row_reg == '0) && (sh_k_reg == '0);
                disp_k_reg      <= sh_k_reg;
                disp_last_reg   <= (sh_row_reg == ROW_W'(ROWS - 1)) && (sh_k_reg == nb_reg - BITS_W'(1));
                pend_reg        <= 1'b0;
                state_reg       <= S_LATCH;
            end
            if (i_clr_uflow)
                uflow_cnt_reg <= '0;
            else if (uflow_evt && uflow_cnt_reg != 16'hFFFF)
                uflow_cnt_reg <= uflow_cnt_reg + 16'd1;
        end
    end

    assign o_tx_start    = tx_start_reg;
    assign o_init_addr   = init_addr_reg;
    assign o_pix_bit     = pix_bit_reg;
    assign o_latch       = latch_reg;
    assign o_oe_n        = oe_n_reg;
    assign o_row_addr    = row_addr_reg;
    assign o_frame_start = frame_start_reg;
    assign o_frame_done  = frame_done_reg;
    assign o_uflow_cnt   = uflow_cnt_reg;
endmodule
